alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Controller in front of the register-file/ALU datapath.
- Accepts 32-bit micro-op words over a valid/ready handshake and decodes them into the datapath control inputs (read_reg1, read_reg2, write_reg, ALU_Sel, Shamt, write_enable).
- Executes each micro-op 1 to 64 times, with an optional stop-when-zero exit, then returns the final ALU result and Zero flag over a response handshake.
- Allows iterative operations (accumulate, shift loops, count-down) with no per-cycle external control.

Parameters:
- DATA_W, 32, ALU/register data width.
- REG_AW, 5, register address width.
- RPT_W, 6, repeat-count field width (max 2^RPT_W iterations).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  micro-op word valid.
- instr_ready  out  1  sequencer can accept a micro-op.
- instr_data  in  32  micro-op word (format in Behaviour).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  DATA_W  ALU result of the last executed iteration.
- rsp_zero  out  1  Zero flag of the last executed iteration.
- rsp_iters  out  RPT_W+1  number of iterations executed.
- busy  out  1  high in EXEC or RESP.
- read_reg1  out  REG_AW  to datapath.
- read_reg2  out  REG_AW  to datapath.
- write_reg  out  REG_AW  to datapath.
- ALU_Sel  out  4  to datapath, passed through opaque.
- Shamt  out  5  to datapath.
- write_enable  out  1  to datapath.
- ALU_result  in  DATA_W  from datapath.
- Zero_flag  in  1  from datapath.

Behaviour:
- Micro-op format:
  - [31:28] alu_sel
  - [27:23] rd
  - [22:18] rs1
  - [17:13] rs2
  - [12:8] shamt
  - [7] we
  - [6] stop_on_zero
  - [5:0] rpt
  - Iteration count = rpt + 1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch all fields into control registers, clear the iteration counter, go to EXEC.
- EXEC, one cycle per iteration:
  - Control outputs come from the latched fields.
  - write_enable = we (registered field, no combinational dependence on Zero_flag).
  - At the clock edge: iteration counter += 1; ALU_result and Zero_flag are captured into rsp_result and rsp_zero.
  - Go to RESP if the counter reaches rpt+1, or if stop_on_zero=1 and Zero_flag=1 this cycle.
  - A write in the terminating iteration still occurs.
- RESP:
  - rsp_valid = 1; rsp_result, rsp_zero and rsp_iters are held stable.
  - On rsp_ready, go to IDLE.
  - instr_ready = 0. A new micro-op is accepted no earlier than the cycle after the response handshake.
- Latency: micro-op accepted in cycle T → EXEC in cycles T+1..T+N → rsp_valid from T+N+1.
- Outputs outside EXEC:
  - write_enable = 0.
  - read/write addresses, ALU_Sel and Shamt hold their last latched values. They are don't-care to the datapath, but must not glitch write_enable.
- Register reads are combinational and writes take effect at the clock edge, so iteration k+1 observes the write from iteration k. rs1 == rd accumulation is legal.
- rpt = 0 → single iteration. rpt = 63 → 64 iterations; rsp_iters = 64 needs RPT_W+1 bits.
- rd = 0 follows register-file semantics; the sequencer does not special-case it.
- Reset (rst low, asynchronous, any state):
  - State = IDLE; all latched fields, counter and response registers = 0.
  - write_enable = 0 and rsp_valid = 0 immediately, not at the next edge.
  - busy = 0.
  - instr_ready = 1, but no transfer is recognised while rst is low.
  - An in-flight micro-op is discarded with no response.
- instr_valid may drop without acceptance; no transfer occurs.

Decomposition:
- Shared package alu_seq_pkg:
  - State enum: IDLE, EXEC, RESP.
  - Micro-op field LSB/MSB constants.
  - ALU_Sel code constants used by benches and software (ADD, SUB, SLL, …).
- Optional sub-module alu_op_decoder: purely combinational field extraction from instr_data.
- The FSM, counter and response registers stay in alu_op_sequencer.
- Top-level integration instantiates alu_op_sequencer alongside the register file and ALU.

Test Plan:
- Single ADD: preload r1=5, r2=7; op ADD rd=3 rs1=1 rs2=2 we=1 rpt=0 → write_enable high exactly one cycle with write_reg=3; rsp_valid at T+2; rsp_result=12, rsp_zero=0, rsp_iters=1.
- Accumulate: r1=5, r2=7; ADD rd=1 rs1=1 rs2=2 we=1 rpt=3 → 4 consecutive write cycles; r1=33; rsp_result=33, rsp_iters=4.
- Count-down stop: r4=3, r5=1; SUB rd=4 rs1=4 rs2=5 we=1 stop_on_zero=1 rpt=63 → exits after 3 iterations; r4=0; rsp_zero=1, rsp_iters=3, rsp_result=0.
- Backpressure: hold rsp_ready=0 for 5 cycles with instr_valid=1 → rsp_valid and rsp_result stable, instr_ready=0, no writes; next op accepted only the cycle after rsp_ready=1.
- Compare-only: SUB rs1=rs2=2, we=1 then repeat with we=0 → with we=0, no write_enable pulse and register contents unchanged; rsp_zero=1.
- Reset mid-op: rpt=5, drive rst low during the 3rd EXEC cycle → write_enable and rsp_valid fall asynchronously, busy=0; after release, IDLE with instr_ready=1 and no stale response.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU micro-op sequencer: FSM states, micro-op
// field layout and the ALU_Sel codes used by software and benches.
package alu_seq_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} seq_state_t;

  localparam int F_SEL_MSB = 31, F_SEL_LSB = 28;
  localparam int F_RD_MSB  = 27, F_RD_LSB  = 23;
  localparam int F_RS1_MSB = 22, F_RS1_LSB = 18;
  localparam int F_RS2_MSB = 17, F_RS2_LSB = 13;
  localparam int F_SH_MSB  = 12, F_SH_LSB  = 8;
  localparam int F_WE      = 7;
  localparam int F_SOZ     = 6;
  localparam int F_RPT_MSB = 5,  F_RPT_LSB = 0;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] shamt;
    logic       we;
    logic       soz;
    logic [5:0] rpt;
  } uop_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational field extraction of a 32-bit micro-op word.
module alu_op_decoder
  import alu_seq_pkg::*;
(
  input  logic [31:0] i_word,
  output uop_t        o_uop
);

  always_comb begin
    o_uop         = '0;
    o_uop.alu_sel = i_word[F_SEL_MSB:F_SEL_LSB];
    o_uop.rd      = i_word[F_RD_MSB:F_RD_LSB];
    o_uop.rs1     = i_word[F_RS1_MSB:F_RS1_LSB];
    o_uop.rs2     = i_word[F_RS2_MSB:F_RS2_LSB];
    o_uop.shamt   = i_word[F_SH_MSB:F_SH_LSB];
    o_uop.we      = i_word[F_WE];
    o_uop.soz     = i_word[F_SOZ];
    o_uop.rpt     = i_word[F_RPT_MSB:F_RPT_LSB];
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Micro-op sequencer: latches a micro-op, drives the register-file/ALU controls
// for 1..2^RPT_W iterations (optional stop-on-zero) and returns the last result.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int RPT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [RPT_W:0]    rsp_iters,
  output logic              busy,
  output logic [REG_AW-1:0] read_reg1,
  output logic [REG_AW-1:0] read_reg2,
  output logic [REG_AW-1:0] write_reg,
  output logic [3:0]        ALU_Sel,
  output logic [4:0]        Shamt,
  output logic              write_enable,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic              Zero_flag
);

  seq_state_t        r_state, w_next;
  uop_t              r_uop, w_dec;
  logic [RPT_W:0]    r_cnt;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              w_accept, w_last;

  alu_op_decoder u_dec (
    .i_word (instr_data),
    .o_uop  (w_dec)
  );

  assign w_accept = instr_valid & instr_ready;
  // Count is pre-increment, so r_cnt == rpt marks the (rpt+1)-th iteration.
  assign w_last   = (r_cnt == {1'b0, r_uop.rpt}) | (r_uop.soz & Zero_flag);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next = EXEC;
      EXEC:    if (w_last)    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_uop    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_uop <= w_dec;
        r_cnt <= '0;
      end
      if (r_state == EXEC) begin
        r_cnt    <= r_cnt + 1'b1;
        r_result <= ALU_result;
        r_zero   <= Zero_flag;
      end
    end
  end

  // write_enable depends only on registered state so reset kills it at once.
  assign write_enable = (r_state == EXEC) & r_uop.we;
  assign instr_ready  = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign rsp_valid    = (r_state == RESP);
  assign rsp_result   = r_result;
  assign rsp_zero     = r_zero;
  assign rsp_iters    = r_cnt;
  assign read_reg1    = r_uop.rs1;
  assign read_reg2    = r_uop.rs2;
  assign write_reg    = r_uop.rd;
  assign ALU_Sel      = r_uop.alu_sel;
  assign Shamt        = r_uop.shamt;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: sequencer driving a small register-file/ALU model.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk, rst;
  logic        instr_valid, instr_ready, rsp_valid, rsp_ready, rsp_zero, busy;
  logic [31:0] instr_data, rsp_result, ALU_result;
  logic [6:0]  rsp_iters;
  logic [4:0]  read_reg1, read_reg2, write_reg, Shamt;
  logic [3:0]  ALU_Sel;
  logic        write_enable, Zero_flag;

  logic [31:0] rf [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;
  int          wr_cnt = 0;
  int          tests = 0, fails = 0;
  int          wr0, n;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_iters(rsp_iters), .busy(busy),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
    .ALU_Sel(ALU_Sel), .Shamt(Shamt), .write_enable(write_enable),
    .ALU_result(ALU_result), .Zero_flag(Zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: combinational ALU on register reads, r0 reads as zero.
  always_comb begin
    logic [31:0] a, b;
    a = rf[read_reg1];
    b = rf[read_reg2];
    case (ALU_Sel)
      ALU_ADD: ALU_result = a + b;
      ALU_SUB: ALU_result = a - b;
      ALU_AND: ALU_result = a & b;
      ALU_OR:  ALU_result = a | b;
      ALU_XOR: ALU_result = a ^ b;
      ALU_SLL: ALU_result = a << Shamt;
      ALU_SRL: ALU_result = a >> Shamt;
      default: ALU_result = '0;
    endcase
    Zero_flag = (ALU_result == 32'd0);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (pl_en) rf[pl_addr] <= pl_data;
      else if (write_enable && write_reg != 5'd0) rf[write_reg] <= ALU_result;
      if (write_enable) wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] sel, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] sh,
      input logic we, input logic soz, input logic [5:0] rpt);
    return {sel, rd, rs1, rs2, sh, we, soz, rpt};
  endfunction

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Ends at the negedge of the first EXEC cycle.
  task automatic issue(input string tag, input logic [31:0] w);
    @(negedge clk);
    instr_data = w; instr_valid = 1'b1;
    chk({tag, "_ready"}, instr_ready, 1'b1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    wr0 = wr_cnt;
  endtask

  task automatic wait_rsp(input string tag, input int exp_n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, exp_n);
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_idle"}, {rsp_valid, instr_ready, busy}, 3'b010);
  endtask

  initial begin
    rst = 1'b0; instr_valid = 1'b0; instr_data = '0; rsp_ready = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_outs", {rsp_valid, busy, write_enable}, 3'b000);
    chk("rst_rsp", {rsp_iters, rsp_zero, rsp_result}, '0);
    rst = 1'b1;

    // single ADD: r3 = 5 + 7
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    issue("add", mk(ALU_ADD, 5'd3, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 6'd0));
    chk("add_we", {write_enable, write_reg}, {1'b1, 5'd3});
    chk("add_novalid", rsp_valid, 1'b0);
    wait_rsp("add", 1);
    chk("add_rsp", {rsp_iters, rsp_zero, rsp_result}, {7'd1, 1'b0, 32'd12});
    chk("add_writes", wr_cnt - wr0, 1);
    chk("add_r3", rf[3], 32'd12);
    take_rsp("add");

    // accumulate: r1 += r2 four times -> 33
    issue("acc", mk(ALU_ADD, 5'd1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 6'd3));
    wait_rsp("acc", 4);
    chk("acc_rsp", {rsp_iters, rsp_zero, rsp_result}, {7'd4, 1'b0, 32'd33});
    chk("acc_writes", wr_cnt - wr0, 4);
    chk("acc_r1", rf[1], 32'd33);
    take_rsp("acc");

    // count-down with stop-on-zero: 3 -> 2 -> 1 -> 0
    preload(5'd4, 32'd3);
    preload(5'd5, 32'd1);
    issue("cnt", mk(ALU_SUB, 5'd4, 5'd4, 5'd5, 5'd0, 1'b1, 1'b1, 6'd63));
    wait_rsp("cnt", 3);
    chk("cnt_rsp", {rsp_iters, rsp_zero, rsp_result}, {7'd3, 1'b1, 32'd0});
    chk("cnt_writes", wr_cnt - wr0, 3);
    chk("cnt_r4", rf[4], 32'd0);

    // backpressure with a pending micro-op: r6 = r1 + r2 = 40
    instr_data = mk(ALU_ADD, 5'd6, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 6'd0);
    instr_valid = 1'b1;
    wr0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, instr_ready, write_enable, rsp_result},
          {3'b100, 32'd0});
      @(negedge clk);
    end
    chk("bp_writes", wr_cnt - wr0, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_idle", {rsp_valid, instr_ready, busy}, 3'b010);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("bp_accept", {busy, write_enable, write_reg}, {2'b11, 5'd6});
    wait_rsp("bp", 1);
    chk("bp_rsp", {rsp_iters, rsp_result}, {7'd1, 32'd40});
    take_rsp("bp");

    // compare-only: we=1 writes zero, we=0 leaves target untouched
    preload(5'd7, 32'd99);
    preload(5'd8, 32'd99);
    issue("cmpw", mk(ALU_SUB, 5'd7, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0, 6'd0));
    wait_rsp("cmpw", 1);
    chk("cmpw_rsp", {rsp_zero, rsp_result, rf[7]}, {1'b1, 32'd0, 32'd0});
    take_rsp("cmpw");
    issue("cmp", mk(ALU_SUB, 5'd8, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 6'd0));
    chk("cmp_nowe", write_enable, 1'b0);
    wait_rsp("cmp", 1);
    chk("cmp_rsp", {rsp_zero, rsp_result, rf[8]}, {1'b1, 32'd0, 32'd99});
    chk("cmp_writes", wr_cnt - wr0, 0);
    take_rsp("cmp");

    // maximum repeat: 64 iterations of r10 += r11
    preload(5'd11, 32'd1);
    issue("max", mk(ALU_ADD, 5'd10, 5'd10, 5'd11, 5'd0, 1'b1, 1'b0, 6'd63));
    wait_rsp("max", 64);
    chk("max_rsp", {rsp_iters, rsp_result}, {7'd64, 32'd64});
    chk("max_writes", wr_cnt - wr0, 64);
    take_rsp("max");

    // shift with shamt
    preload(5'd12, 32'h0000_0003);
    issue("sll", mk(ALU_SLL, 5'd13, 5'd12, 5'd0, 5'd4, 1'b1, 1'b0, 6'd1));
    wait_rsp("sll", 2);
    chk("sll_rsp", {rsp_iters, rsp_result, rf[13]}, {7'd2, 32'h30, 32'h30});
    take_rsp("sll");

    // asynchronous reset in the third EXEC cycle
    preload(5'd9, 32'd1);
    issue("mrst", mk(ALU_ADD, 5'd9, 5'd9, 5'd2, 5'd0, 1'b1, 1'b0, 6'd5));
    repeat (2) @(negedge clk);
    chk("mrst_pre", {write_enable, rsp_iters}, {1'b1, 7'd2});
    chk("mrst_writes", wr_cnt - wr0, 2);
    #1 rst = 1'b0;
    #1;
    chk("mrst_async", {write_enable, rsp_valid, busy, instr_ready}, 4'b0001);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_after", {rsp_valid, busy, instr_ready, rsp_iters}, {3'b001, 7'd0});
    repeat (3) @(negedge clk);
    chk("mrst_stale", {rsp_valid, busy, write_enable}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
